// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, colour names, pixel record and address mapping
// for the 160x120 3-bit framebuffer.
package fb_pkg;
  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pix_t;

  // y*160 + x as shift-adds
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 7) + (yy << 5) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/fb_region_reader_if.sv
// Framebuffer RAM read port plus the outgoing pixel stream of the region reader.
interface fb_region_reader_if;
  import fb_pkg::*;

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  logic                pix_valid;
  logic                pix_ready;
  logic [7:0]          pix_x;
  logic [6:0]          pix_y;
  logic [COLOUR_W-1:0] pix_colour;

  modport master (
    output rd_en, rd_addr, pix_valid, pix_x, pix_y, pix_colour,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_valid, pix_x, pix_y, pix_colour,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/fb_pix_fifo2.sv
// Two-entry pixel FIFO, head always in e0 so the output is a plain register.
module fb_pix_fifo2
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  pix_t       din,
  input  logic       pop,
  output pix_t       dout,
  output logic       valid,
  output logic [1:0] count
);
  pix_t e0, e1;
  logic do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign valid = (count != 2'd0);
endmodule

// File: rtl/fb_region_reader.sv
// Scans a clipped rectangle of the framebuffer, streams {x, y, colour} over a
// valid/ready port and counts pixels matching a target colour.
module fb_region_reader
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          x0,
  input  logic [6:0]          y0,
  input  logic [7:0]          w,
  input  logic [6:0]          h,
  input  logic [COLOUR_W-1:0] target_colour,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   match_count,
  fb_region_reader_if.master  bus
);
  // state | meaning
  // IDLE  | waiting for start
  // SCAN  | issuing reads row-major over the clipped region
  // DRAIN | last read issued; waiting for in-flight data and FIFO to empty
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t              state;
  logic [7:0]          x_cnt, x_start, x_last;
  logic [6:0]          y_cnt, y_last;
  logic [COLOUR_W-1:0] tgt;
  logic                empty_q, inflight;
  logic [7:0]          tag_x;
  logic [6:0]          tag_y;

  logic [8:0] x_sum;
  logic [7:0] y_sum, x_end;
  logic [6:0] y_end;
  logic       region_empty;

  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};
  assign x_end = (x_sum > 9'(H_RES)) ? 8'(H_RES) : x_sum[7:0];
  assign y_end = (y_sum > 8'(V_RES)) ? 7'(V_RES) : y_sum[6:0];
  assign region_empty = (w == 8'd0) || (h == 7'd0) ||
                        (x0 >= 8'(H_RES)) || (y0 >= 7'(V_RES));

  pix_t       fifo_din, fifo_dout;
  logic       fifo_valid, pop, rd_en;
  logic [1:0] fifo_count;
  logic [2:0] occ;

  assign pop      = fifo_valid && bus.pix_ready;
  assign fifo_din = '{x: tag_x, y: tag_y, colour: bus.rd_data};

  fb_pix_fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  // Never let queued plus in-flight pixels exceed the FIFO depth.
  assign occ   = 3'(fifo_count) + 3'(inflight);
  assign rd_en = (state == SCAN) && !empty_q && ((occ - 3'(pop)) < 3'd2);

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = xy_to_addr(x_cnt, y_cnt);
  assign bus.pix_valid  = fifo_valid;
  assign bus.pix_x      = fifo_dout.x;
  assign bus.pix_y      = fifo_dout.y;
  assign bus.pix_colour = fifo_dout.colour;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      x_start     <= '0;
      x_last      <= '0;
      y_last      <= '0;
      tgt         <= '0;
      empty_q     <= 1'b0;
      inflight    <= 1'b0;
      tag_x       <= '0;
      tag_y       <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;
      if (rd_en) begin
        tag_x <= x_cnt;
        tag_y <= y_cnt;
      end
      if (pop && (fifo_dout.colour == tgt) && (match_count != '1))
        match_count <= match_count + ADDR_W'(1);

      unique case (state)
        IDLE: if (start) begin
          state       <= SCAN;
          busy        <= 1'b1;
          match_count <= '0;
          x_cnt       <= x0;
          y_cnt       <= y0;
          x_start     <= x0;
          x_last      <= x_end - 8'd1;
          y_last      <= y_end - 7'd1;
          tgt         <= target_colour;
          empty_q     <= region_empty;
        end
        SCAN: begin
          if (empty_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (rd_en) begin
            if (x_cnt == x_last) begin
              x_cnt <= x_start;
              if (y_cnt == y_last) state <= DRAIN;
              else                 y_cnt <= y_cnt + 7'd1;
            end else begin
              x_cnt <= x_cnt + 8'd1;
            end
          end
        end
        // Finish on the cycle the final pixel leaves the FIFO.
        DRAIN: if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_region_reader.sv
// Randomised scoreboard bench for fb_region_reader against a RAM model and a
// plain nested-loop region reference.
module tb_fb_region_reader;
  import fb_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [7:0]          x0 = '0;
  logic [6:0]          y0 = '0;
  logic [7:0]          w = '0;
  logic [6:0]          h = '0;
  logic [COLOUR_W-1:0] target_colour = '0;
  logic                busy, done;
  logic [ADDR_W-1:0]   match_count;

  fb_region_reader_if bus();

  fb_region_reader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .x0            (x0),
    .y0            (y0),
    .w             (w),
    .h             (h),
    .target_colour (target_colour),
    .busy          (busy),
    .done          (done),
    .match_count   (match_count),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  logic [COLOUR_W-1:0] ram [H_RES*V_RES];
  always @(posedge clk) if (bus.rd_en === 1'b1) bus.rd_data <= ram[bus.rd_addr];

  int total = 0, bad = 0, cyc = 0;
  int rd_count = 0, pop_count = 0, done_cnt = 0;
  int first_valid = -1, first_pop = -1, last_pop = -1, run_pops = 0;
  int rmode = 0, rpat = 0, exp_match = 0;
  bit mon_en = 1'b0, stall_prev = 1'b0;
  logic [17:0] prev_pix = '0;
  logic [17:0] exp_q[$];
  int          addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: bus.pix_ready = 1'b1;
      1: begin bus.pix_ready = (rpat % 3 == 0); rpat++; end
      default: bus.pix_ready = 1'($urandom_range(1));
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [17:0] pk(input int x, input int y, input int c);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;
    xx = 8'(x); yy = 7'(y); cc = 3'(c);
    return {xx, yy, cc};
  endfunction

  // Reference: every on-screen pixel of the requested rectangle, row-major.
  task automatic model_region(input int xv, input int yv, input int wv, input int hv, input int tgt);
    int xe, ye;
    xe = (xv + wv > H_RES) ? H_RES : xv + wv;
    ye = (yv + hv > V_RES) ? V_RES : yv + hv;
    exp_match = 0;
    for (int y = yv; y < ye; y++)
      for (int x = xv; x < xe; x++) begin
        exp_q.push_back(pk(x, y, int'(ram[y*H_RES + x])));
        addr_q.push_back(y*H_RES + x);
        if (int'(ram[y*H_RES + x]) == tgt) exp_match++;
      end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] cur;
      bit popi;
      cur  = {bus.pix_x, bus.pix_y, bus.pix_colour};
      popi = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1);
      if (bus.rd_en === 1'b1) begin
        if (addr_q.size() == 0) flag("rd_en_unexpected");
        else chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
        chk("rd_occupancy", 64'((rd_count - pop_count) + 1 - int'(popi) <= 2), 64'd1);
        rd_count++;
      end
      if (stall_prev) chk("stall_hold", {bus.pix_valid, cur}, {1'b1, prev_pix});
      if (bus.pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (popi) begin
        if (exp_q.size() == 0) flag("pixel_unexpected");
        else chk("pixel", 64'(cur), 64'(exp_q.pop_front()));
        pop_count++;
        run_pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      stall_prev = (bus.pix_valid === 1'b1) && (bus.pix_ready !== 1'b1);
      prev_pix   = cur;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic run_region(input int xv, input int yv, input int wv, input int hv,
                            input int tgt, input int mode, input bit poke);
    int s, n, rd0, dn0, dcyc;
    bit got;
    model_region(xv, yv, wv, hv, tgt);
    n = exp_q.size();
    rmode = mode;
    rpat  = 0;
    @(posedge clk); #1;
    x0 = 8'(xv); y0 = 7'(yv); w = 8'(wv); h = 7'(hv);
    target_colour = 3'(tgt);
    start = 1'b1;
    s = cyc;
    first_valid = -1; first_pop = -1; last_pop = -1; run_pops = 0;
    rd0 = rd_count; dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    got = 1'b0; dcyc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin got = 1'b1; dcyc = cyc; break; end
      if (poke && i == 3) begin
        start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd50; h = 7'd50; target_colour = ~3'(tgt);
      end
      if (poke && i == 4) start = 1'b0;
      @(negedge clk);
    end
    #1;
    if (!got) flag("done_timeout");
    chk("match_count_at_done", 64'(match_count), 64'(exp_match));
    chk("pixels_left", 64'(exp_q.size()), 64'd0);
    chk("pixel_count", 64'(run_pops), 64'(n));
    if (n == 0) begin
      chk("empty_done_latency", 64'(dcyc - s), 64'd2);
      chk("empty_reads", 64'(rd_count - rd0), 64'd0);
    end else if (mode == 0) begin
      chk("first_valid_latency", 64'(first_valid - s), 64'd3);
      chk("back_to_back", 64'(last_pop - first_pop), 64'(n - 1));
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - dn0), 64'd1);
    chk("match_stable", 64'(match_count), 64'(exp_match));
    chk("busy_idle", 64'(busy), 64'd0);
    exp_q.delete();
    addr_q.delete();
    start = 1'b0;
  endtask

  task automatic run_abort();
    int dn0;
    model_region(30, 40, 20, 20, int'(GREEN));
    rmode = 2;
    @(posedge clk); #1;
    x0 = 8'd30; y0 = 7'd40; w = 8'd20; h = 7'd20; target_colour = GREEN;
    start = 1'b1;
    dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete(); addr_q.delete();
    rd_count = 0; pop_count = 0; stall_prev = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rd_en", 64'(bus.rd_en), 64'd0);
    chk("abort_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("abort_pix", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_colour}, 64'd0);
    chk("abort_match", 64'(match_count), 64'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - dn0), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < H_RES*V_RES; i++) ram[i] = 3'($urandom_range(7));
    ram[5*H_RES + 10] = YELLOW;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_en", 64'(bus.rd_en), 64'd0);
    chk("reset_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("reset_match", 64'(match_count), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_region(10, 5, 1, 1, int'(YELLOW), 0, 1'b0);
    run_region(67, 60, 5, 3, int'(RED), 0, 1'b0);
    run_region(67, 60, 5, 3, int'(BLUE), 1, 1'b0);
    run_region(158, 118, 5, 5, int'(WHITE), 0, 1'b0);
    run_region(158, 118, 5, 5, int'(BLACK), 1, 1'b0);
    run_region(40, 40, 0, 6, int'(BLACK), 0, 1'b0);
    run_region(200, 10, 4, 4, int'(BLACK), 0, 1'b0);
    run_region(10, 125, 4, 4, int'(BLACK), 0, 1'b0);
    run_region(20, 20, 6, 4, int'(CYAN), 1, 1'b1);
    run_abort();
    run_region(30, 40, 20, 20, int'(GREEN), 0, 1'b0);
    for (int k = 0; k < 8; k++)
      run_region($urandom_range(165), $urandom_range(125), $urandom_range(24),
                 $urandom_range(16), $urandom_range(7), $urandom_range(2), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
